// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the run-time clock divider controller.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    localparam int DIV_MIN = 2;

    // Last count value of the low phase for a ratio n.
    function automatic logic [31:0] half(input logic [31:0] n);
        return (n - 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_cnt.sv
// Period counter: counts 0..div-1 and reports the wrap and high-phase decodes.
module clk_div_cnt
    import clk_div_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [CNT_W-1:0] div,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             hi
);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] half_n;

    assign half_n = CNT_W'(half(32'(div)));
    // >= keeps the counter bounded even if the ratio ever shrinks mid-period.
    assign wrap   = (count_reg >= (div - 1'b1));
    assign hi     = (count_reg > half_n);
    assign count  = count_reg;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr || wrap) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Divided clock / period strobe generator with glitch-free ratio change, start and stop.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 5
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_req,
    output logic             div_ack,
    output logic             clk_out,
    output logic             tick,
    output logic             busy
);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] div_cur_reg;
    logic [CNT_W-1:0] div_pend_reg;
    logic             pend_vld_reg;
    logic             div_ack_reg;
    logic             clk_out_reg;
    logic             tick_reg;

    logic [CNT_W-1:0] count;
    logic             wrap;
    logic             hi;
    logic             idle;
    logic             capture;
    logic             apply_pend;
    logic [CNT_W-1:0] div_clamped;

    clk_div_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .clr    (idle),
        .div    (div_cur_reg),
        .count  (count),
        .wrap   (wrap),
        .hi     (hi)
    );

    assign idle        = (state_reg == IDLE);
    assign div_clamped = (div_in < CNT_W'(DIV_MIN)) ? CNT_W'(DIV_MIN) : div_in;
    assign capture     = div_req && !pend_vld_reg && !div_ack_reg;
    // A change captured on the final stopping wrap lands in IDLE and is applied there.
    assign apply_pend  = pend_vld_reg && (idle || wrap);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (en) state_next = RUN;
            RUN:      if (!en) state_next = STOPPING;
            STOPPING: begin
                if (en)        state_next = RUN;
                else if (wrap) state_next = IDLE;
            end
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            div_cur_reg  <= CNT_W'(DEF_DIV);
            div_pend_reg <= '0;
            pend_vld_reg <= 1'b0;
            div_ack_reg  <= 1'b0;
            clk_out_reg  <= 1'b0;
            tick_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            div_ack_reg <= (capture && idle) || apply_pend;
            clk_out_reg <= !idle && hi;
            tick_reg    <= !idle && wrap;

            if (apply_pend) begin
                div_cur_reg  <= div_pend_reg;
                pend_vld_reg <= 1'b0;
            end else if (capture && idle) begin
                div_cur_reg <= div_clamped;
            end else if (capture) begin
                div_pend_reg <= div_clamped;
                pend_vld_reg <= 1'b1;
            end
        end
    end

    assign div_ack = div_ack_reg;
    assign clk_out = clk_out_reg;
    assign tick    = tick_reg;
    assign busy    = !idle || pend_vld_reg;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl.
module tb_clk_div_ctrl;

    localparam int CNT_W = 8;

    logic             clk_in = 1'b0;
    logic             rst_n;
    logic             en;
    logic [CNT_W-1:0] div_in;
    logic             div_req;
    logic             div_ack;
    logic             clk_out;
    logic             tick;
    logic             busy;

    int errors = 0;
    int checks = 0;
    int n;

    // Expected clk_out shapes, bit i = phase i of the period.
    logic [4:0] pat5   = 5'b11000;
    logic [7:0] pat8   = 8'b11110000;
    logic [1:0] pat2   = 2'b10;
    logic [6:0] s_clk  = 7'b0001100;
    logic [6:0] s_tick = 7'b0001000;
    logic [6:0] s_busy = 7'b0000111;

    clk_div_ctrl #(
        .CNT_W   (CNT_W),
        .DEF_DIV (5)
    ) dut (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .en      (en),
        .div_in  (div_in),
        .div_req (div_req),
        .div_ack (div_ack),
        .clk_out (clk_out),
        .tick    (tick),
        .busy    (busy)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; div_req = 1'b0; div_in = '0;
        step(); step();
        check("rst_clk", clk_out, 0);
        check("rst_tick", tick, 0);
        check("rst_ack", div_ack, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        step();
        check("idle_clk", clk_out, 0);
        check("idle_busy", busy, 0);

        // Start at the default ratio of 5
        en = 1'b1;
        step();
        check("start_busy", busy, 1);
        check("start_clk", clk_out, 0);
        for (int k = 1; k <= 10; k++) begin
            step();
            check("n5_clk", clk_out, pat5[(k-1)%5]);
            check("n5_tick", tick, (k % 5 == 0));
        end

        // Request ratio 8 at count=1; applied at the wrap
        step();
        check("req8_c1_clk", clk_out, pat5[0]);
        div_req = 1'b1; div_in = 8'd8;
        for (int j = 1; j <= 4; j++) begin
            step();
            check("req8_clk", clk_out, pat5[j]);
            check("req8_tick", tick, (j == 4));
            check("req8_ack", div_ack, (j == 4));
        end
        div_req = 1'b0;
        for (int j = 0; j < 8; j++) begin
            step();
            check("n8_clk", clk_out, pat8[j]);
            check("n8_tick", tick, (j == 7));
            check("n8_ack", div_ack, 0);
        end

        // Stop at count=0 of N=8: full period completes
        en = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (busy && n < 20);
        check("stop8_len", n, 8);
        check("stop8_last_clk", clk_out, 1);
        check("stop8_last_tick", tick, 1);
        step();
        check("stop8_idle_clk", clk_out, 0);

        // Ratio request in IDLE, clamped to 2
        div_req = 1'b1; div_in = 8'd0;
        step();
        check("idle_req_ack", div_ack, 1);
        check("idle_req_busy", busy, 0);
        div_req = 1'b0;
        step();
        check("idle_req_ack_low", div_ack, 0);
        en = 1'b1;
        step();
        for (int k = 1; k <= 6; k++) begin
            step();
            check("n2_clk", clk_out, pat2[(k-1)%2]);
            check("n2_tick", tick, pat2[(k-1)%2]);
        end

        // Back to ratio 5 while running at N=2
        div_req = 1'b1; div_in = 8'd5;
        n = 0;
        do begin
            step();
            n++;
        end while (!div_ack && n < 20);
        check("req5_latency", n, 2);
        div_req = 1'b0;

        // Drop en at count=1 of N=5
        step();
        en = 1'b0;
        for (int j = 0; j < 7; j++) begin
            step();
            check("stop5_clk", clk_out, s_clk[j]);
            check("stop5_tick", tick, s_tick[j]);
            check("stop5_busy", busy, s_busy[j]);
        end

        // Drop and re-raise en before the wrap: no disturbance
        en = 1'b1;
        step();
        for (int k = 1; k <= 15; k++) begin
            step();
            check("bump_clk", clk_out, pat5[(k-1)%5]);
            check("bump_tick", tick, (k % 5 == 0));
            check("bump_busy", busy, 1);
            if (k == 6) en = 1'b0;
            if (k == 7) en = 1'b1;
        end

        // Reset during a high phase with a pending request
        step(); step();
        div_req = 1'b1; div_in = 8'd8;
        step(); step();
        check("pre_rst_clk", clk_out, 1);
        check("pre_rst_busy", busy, 1);
        check("pre_rst_ack", div_ack, 0);
        #2;
        rst_n = 1'b0; div_req = 1'b0; en = 1'b0;
        #1;
        check("async_rst_clk", clk_out, 0);
        check("async_rst_tick", tick, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_ack", div_ack, 0);
        step(); step();
        rst_n = 1'b1;
        step();
        en = 1'b1;
        step();
        for (int k = 1; k <= 10; k++) begin
            step();
            check("post_rst_clk", clk_out, pat5[(k-1)%5]);
            check("post_rst_tick", tick, (k % 5 == 0));
            check("post_rst_ack", div_ack, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Run-time controller for the system clock divider. It generates a divided clock and a one-cycle period strobe from `clk_in`, with a divide ratio that can be changed through a request/acknowledge handshake. Ratio changes, start and stop take effect only on period boundaries, so `clk_out` never produces a runt pulse. It sits between the register/config logic and the peripherals clocked or enabled from the divided clock.

## Interface
- `CNT_W`, 8: width of the divide-ratio and period counter.
- `DEF_DIV`, 5: divide ratio loaded at reset (50 MHz -> 10 MHz); must be >= 2.

- `clk_in`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  run request; level-sensitive.
- `div_in`  in  CNT_W  requested divide ratio N; must be held stable while `div_req` is high.
- `div_req`  in  1  ratio-change request; held high until `div_ack` is seen.
- `div_ack`  out  1  one-cycle pulse when the requested ratio becomes active.
- `clk_out`  out  1  divided clock, registered.
- `tick`  out  1  one-cycle strobe in the last cycle of each period, registered.
- `busy`  out  1  high when the state is not IDLE or a ratio change is pending.

## Operation
- Registers:
  - `div_cur`: active ratio N.
  - `div_pend` plus `pend_vld`: captured ratio change.
  - `count`: 0..N-1.
  - `state`: one of IDLE, RUN, STOPPING.
- Reset values: `count`=0, `clk_out`=0, `tick`=0, `div_ack`=0, `busy`=0, `pend_vld`=0, `div_cur`=DEF_DIV, state IDLE.
- Ratio clamp: any `div_in` < 2 is captured as 2. Arithmetic is unsigned CNT_W.
- Phase decode: `clk_out` = (`count` > (N-1)>>1) and `tick` = (`count` == N-1), both in RUN/STOPPING. This gives the following shapes:
  - N=5: 3 low, 2 high.
  - N=4: 2 low, 2 high.
  - N=2: 1 low, 1 high.
- IDLE:
  - `clk_out`=0, `tick`=0, `count` held at 0.
  - `en`=1 moves the state to RUN. `count` stays 0 on that edge and then increments.
- RUN:
  - `count` increments each cycle and wraps N-1 -> 0.
  - `en`=0 moves the state to STOPPING.
- STOPPING:
  - Behaves as RUN until the wrap edge, then goes to IDLE with `count`=0 and `clk_out`=0.
  - `en`=1 before the wrap returns the state to RUN with no disturbance to the count.
- Ratio handshake:
  - A request is captured on a cycle where `div_req`=1, `pend_vld`=0 and `div_ack`=0.
  - In IDLE the new ratio is applied on the capture edge.
  - Otherwise it is applied on the next wrap edge: `div_cur` <= `div_pend`, and the new ratio governs the period starting at `count`=0.
  - `div_ack` is high for exactly the cycle after the apply edge.
- Simultaneous events:
  - Capture and wrap on the same edge: the ratio is applied at the following wrap, not the current one.
  - Stop and pending change: the change is still applied at the final wrap.
- Late-request restriction: requests arriving while `pend_vld`=1 are not captured until the pending one is acknowledged. The requester must keep `div_req` high until then.
- Reset mid-operation: asserting `rst_n` low forces all reset values immediately, regardless of phase. Any pending request is discarded.

## Timing
- `en` rise to first `tick`: N cycles, counted from the edge that enters RUN.
- `tick` is high for 1 cycle per period, coincident with the last high cycle of `clk_out`.
- Ratio-change latency: up to N_old+1 cycles from capture to `div_ack`; 1 cycle in IDLE.
- Stop latency: `clk_out` is low from the first edge after the wrap that follows `en` falling. The final high phase is never truncated.
- No combinational path from any input to any output.

## Structure
- Package `clk_div_pkg`:
  - state enum (IDLE, RUN, STOPPING);
  - constant `DIV_MIN`=2;
  - function `half(N)` = (N-1)>>1.
- One sub-module, `clk_div_cnt`: period counter with load/clear/wrap outputs, driven by `div_cur`.
- The FSM and the handshake stay in the top module.

## Test plan
- Reset, then `en`=1 with DEF_DIV=5:
  - `clk_out` pattern 0,0,0,1,1 repeating;
  - `tick` every 5th cycle;
  - `busy`=1.
- In RUN at N=5, request `div_in`=8 at `count`=1:
  - no change until the wrap;
  - `div_ack` pulses the cycle after the wrap;
  - the next period is 4 low, 4 high.
- Request `div_in`=0 in IDLE: `div_ack` arrives 1 cycle later, then `en`=1 gives `clk_out` toggling every cycle (N=2).
- Drop `en` at `count`=1 (N=5):
  - `clk_out` completes its high phase;
  - IDLE is reached after the wrap;
  - `busy` falls and `clk_out` stays 0.
- Drop `en` and re-raise it before the wrap: the period sequence is uninterrupted and `tick` spacing stays 5.
- Assert `rst_n` low during a high phase with a pending request:
  - outputs are 0 immediately;
  - after release N=5 and no `div_ack`.
